bus_dest_decoder: RTL and testbench



---
 rtl/bus_dest_decoder_if.sv | 27 ++
 rtl/bus_dest_decoder.sv | 128 ++++++++++++
 tb/tb_bus_dest_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_dest_decoder_if.sv
// Bus bundle between the microinstruction decoder and the destination decoder.
// master: control unit side (drives select/strobes); slave: decoder side.
interface bus_dest_decoder_if #(
  parameter int unsigned SEL_W = 4
);
  localparam int unsigned NUM_DEST = 1 << SEL_W;

  logic [SEL_W-1:0]    sel;
  logic                en_op;
  logic                en_out;
  logic                err_clr;
  logic [NUM_DEST-1:0] we;
  logic [SEL_W-1:0]    dest_q;
  logic                armed;
  logic                busy;
  logic                err;

  modport master (
    output sel, en_op, en_out, err_clr,
    input  we, dest_q, armed, busy, err
  );

  modport slave (
    input  sel, en_op, en_out, err_clr,
    output we, dest_q, armed, busy, err
  );
endinterface

// File: rtl/bus_dest_decoder.sv
// Registered destination decoder for internal-bus write-enables.
// Latches a destination on en_op, then on en_out drives a one-hot write-enable
// pulse of PULSE_LEN cycles. Illegal selects (VALID_MASK bit clear) raise err.
// Optional macro DEC_ERR_STICKY_EN: err becomes sticky until err_clr or reset;
// otherwise err is a single-cycle pulse and err_clr is unused.
module bus_dest_decoder #(
  parameter int unsigned               SEL_W      = 4,
  parameter logic [(1 << SEL_W)-1:0]   VALID_MASK = 16'h1FF9,
  parameter int unsigned               PULSE_LEN  = 1
) (
  input logic                clk,
  input logic                rst_n,
  bus_dest_decoder_if.slave  bus
);

  localparam int unsigned NUM_DEST  = 1 << SEL_W;
  localparam int unsigned CNT_W     = 4;
  // Zero length is promoted to 1; anything beyond the counter range saturates.
  localparam int unsigned PULSE_EFF = (PULSE_LEN == 0) ? 1 :
                                      (PULSE_LEN > 15) ? 15 : PULSE_LEN;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_EFF - 1);
  localparam logic [NUM_DEST-1:0] ONE   = {{(NUM_DEST-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_DEST-1:0] r_we;
  logic [SEL_W-1:0]    r_dest_q;
  logic                r_armed;
  logic                r_busy;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_legal;
  logic                w_accept;
  logic                w_op_ok;
  logic                w_op_bad;
  logic [SEL_W-1:0]    w_dest_nxt;

  // Strobes are only honoured outside DRIVE; a legal same-cycle select wins.
  assign w_legal    = VALID_MASK[bus.sel];
  assign w_accept   = (r_state != S_DRIVE);
  assign w_op_ok    = bus.en_op & w_legal & w_accept;
  assign w_op_bad   = bus.en_op & ~w_legal & w_accept;
  assign w_dest_nxt = w_op_ok ? bus.sel : r_dest_q;

  // FSM with registered one-hot write-enable, status flags and pulse counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= '0;
      r_dest_q <= '0;
      r_armed  <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_op_ok) begin
        r_dest_q <= bus.sel;
      end
      unique case (r_state)
        S_IDLE, S_ARMED: begin
          if (bus.en_out && (w_op_ok || (r_state == S_ARMED))) begin
            r_state <= S_DRIVE;
            r_we    <= ONE << w_dest_nxt;
            r_busy  <= 1'b1;
            r_armed <= 1'b0;
            r_cnt   <= CNT_LOAD;
          end else if (w_op_ok) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_we    <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= '0;
          r_armed <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEC_ERR_STICKY_EN
  // Sticky error: a new illegal select dominates a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_op_bad) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;

  // Single-cycle error pulse following each illegal select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_op_bad;
    end
  end
`endif

  assign bus.we     = r_we;
  assign bus.dest_q = r_dest_q;
  assign bus.armed  = r_armed;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_bus_dest_decoder.sv
// Bench for bus_dest_decoder: three instances (PULSE_LEN 1, 3, 4) share the
// same stimulus; a transaction-level model predicts every output each cycle,
// and literal expectations pin key points of the scenario.
// Honours DEC_ERR_STICKY_EN for the err behaviour.
module tb_bus_dest_decoder;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned NDUT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] t_sel = '0;
  logic t_op = 1'b0, t_out = 1'b0, t_clr = 1'b0;
  bit chk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_dest_decoder_if #(.SEL_W(SEL_W)) if0 ();
  bus_dest_decoder_if #(.SEL_W(SEL_W)) if1 ();
  bus_dest_decoder_if #(.SEL_W(SEL_W)) if2 ();

  assign if0.sel = t_sel; assign if0.en_op = t_op; assign if0.en_out = t_out; assign if0.err_clr = t_clr;
  assign if1.sel = t_sel; assign if1.en_op = t_op; assign if1.en_out = t_out; assign if1.err_clr = t_clr;
  assign if2.sel = t_sel; assign if2.en_op = t_op; assign if2.en_out = t_out; assign if2.err_clr = t_clr;

  bus_dest_decoder #(.SEL_W(SEL_W), .VALID_MASK(16'h1FF9), .PULSE_LEN(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bus_dest_decoder #(.SEL_W(SEL_W), .VALID_MASK(16'h1FF9), .PULSE_LEN(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bus_dest_decoder #(.SEL_W(SEL_W), .VALID_MASK(16'h1FF9), .PULSE_LEN(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [15:0] a_we[NDUT];
  logic [3:0]  a_dq[NDUT];
  logic        a_armed[NDUT], a_busy[NDUT], a_err[NDUT];

  assign a_we[0] = if0.we; assign a_dq[0] = if0.dest_q; assign a_armed[0] = if0.armed; assign a_busy[0] = if0.busy; assign a_err[0] = if0.err;
  assign a_we[1] = if1.we; assign a_dq[1] = if1.dest_q; assign a_armed[1] = if1.armed; assign a_busy[1] = if1.busy; assign a_err[1] = if1.err;
  assign a_we[2] = if2.we; assign a_dq[2] = if2.dest_q; assign a_armed[2] = if2.armed; assign a_busy[2] = if2.busy; assign a_err[2] = if2.err;

`ifdef DEC_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Model: a pending destination, a count of write-enable cycles still owed.
  logic [15:0] legal_map = 16'h1FF9;
  int  pulse_len[NDUT] = '{1, 3, 4};
  int  m_dest[NDUT];
  bit  m_pending[NDUT];
  int  m_left[NDUT];
  bit  m_err[NDUT];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        m_dest[k] = 0; m_pending[k] = 1'b0; m_left[k] = 0; m_err[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        // Pulse in flight: strobes are dropped.
        m_left[k] = m_left[k] - 1;
        if (!STICKY) m_err[k] = 1'b0;
        else if (t_clr) m_err[k] = 1'b0;
      end else begin
        bit good, bad;
        good = t_op && legal_map[t_sel];
        bad  = t_op && !legal_map[t_sel];
        if (good) m_dest[k] = int'(t_sel);
        if (t_out && (good || m_pending[k])) begin
          m_left[k] = pulse_len[k];
          m_pending[k] = 1'b0;
        end else if (good) begin
          m_pending[k] = 1'b1;
        end
        if (!STICKY) m_err[k] = bad;
        else if (bad) m_err[k] = 1'b1;
        else if (t_clr) m_err[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        logic [15:0] ewe;
        ewe = (m_left[k] > 0) ? (16'h0001 << m_dest[k]) : 16'h0000;
        chk("we",     k, 32'(a_we[k]),    32'(ewe));
        chk("dest_q", k, 32'(a_dq[k]),    32'(m_dest[k]));
        chk("armed",  k, 32'(a_armed[k]), 32'(m_pending[k]));
        chk("busy",   k, 32'(a_busy[k]),  32'(m_left[k] > 0));
        chk("err",    k, 32'(a_err[k]),   32'(m_err[k]));
        chk("onehot", k, 32'($onehot0(a_we[k])), 32'd1);
      end
    end
  end

  // Apply one input vector across one rising edge; returns at the next negedge.
  task automatic drive(input logic [3:0] s, input logic op, input logic out, input logic clr);
    t_sel = s; t_op = op; t_out = out; t_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_we", 0, 32'(a_we[0]), 32'h0);
    chk("rst_dq", 0, 32'(a_dq[0]), 32'h0);
    chk("rst_flags", 0, 32'({a_armed[0], a_busy[0], a_err[0]}), 32'h0);

    // Latch 5, then drive it.
    drive(4'h5, 1'b1, 1'b0, 1'b0);
    chk("t1_armed", 0, 32'(a_armed[0]), 32'h1);
    chk("t1_dq", 0, 32'(a_dq[0]), 32'h5);
    drive(4'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_we", 0, 32'(a_we[0]), 32'h0020);
    chk("t1_busy", 0, 32'(a_busy[0]), 32'h1);
    idle(1);
    chk("t1_we_off", 0, 32'(a_we[0]), 32'h0);
    chk("t1_busy_off", 0, 32'(a_busy[0]), 32'h0);
    idle(4);

    // Fast path with a 3-cycle pulse; en_op during DRIVE is dropped.
    drive(4'hB, 1'b1, 1'b1, 1'b0);
    chk("t2_we_c1", 1, 32'(a_we[1]), 32'h0800);
    drive(4'h3, 1'b1, 1'b0, 1'b0);
    chk("t2_we_c2", 1, 32'(a_we[1]), 32'h0800);
    idle(1);
    chk("t2_we_c3", 1, 32'(a_we[1]), 32'h0800);
    chk("t2_dq", 1, 32'(a_dq[1]), 32'hB);
    idle(1);
    chk("t2_we_end", 1, 32'(a_we[1]), 32'h0);
    idle(3);

    // Illegal select: err, dest_q kept, a bare en_out does nothing.
    drive(4'h1, 1'b1, 1'b0, 1'b0);
    chk("t3_err", 0, 32'(a_err[0]), 32'h1);
    chk("t3_dq", 0, 32'(a_dq[0]), 32'hB);
    chk("t3_armed", 0, 32'(a_armed[0]), 32'h0);
    drive(4'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_we", 0, 32'(a_we[0]), 32'h0);
    chk("t3_err_next", 0, 32'(a_err[0]), STICKY ? 32'h1 : 32'h0);
    idle(1);
    drive(4'h0, 1'b0, 1'b0, 1'b1);

    // Re-latch in ARMED together with en_out: last write wins.
    drive(4'h4, 1'b1, 1'b0, 1'b0);
    chk("t4_dq", 0, 32'(a_dq[0]), 32'h4);
    drive(4'h9, 1'b1, 1'b1, 1'b0);
    chk("t4_we", 0, 32'(a_we[0]), 32'h0200);
    idle(5);

    // Illegal re-latch in ARMED with en_out drives the old destination.
    drive(4'h7, 1'b1, 1'b0, 1'b0);
    drive(4'h2, 1'b1, 1'b1, 1'b0);
    chk("armed_bad_we", 0, 32'(a_we[0]), 32'h0080);
    chk("armed_bad_err", 0, 32'(a_err[0]), 32'h1);
    idle(5);
    drive(4'h0, 1'b0, 1'b0, 1'b1);

    // Async reset in the second cycle of a 4-cycle pulse.
    drive(4'h6, 1'b1, 1'b1, 1'b0);
    chk("t5_we_c1", 2, 32'(a_we[2]), 32'h0040);
    t_sel = 4'h0; t_op = 1'b0; t_out = 1'b0; t_clr = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_we_c2", 2, 32'(a_we[2]), 32'h0040);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 2, 32'(a_we[2]), 32'h0);
    chk("t5_rst_busy", 2, 32'(a_busy[2]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("t5_idle", 2, 32'({a_armed[2], a_busy[2]}), 32'h0);
    drive(4'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_no_we", 2, 32'(a_we[2]), 32'h0);

    // err persistence / clear.
    drive(4'hE, 1'b1, 1'b0, 1'b0);
    chk("t6_err", 0, 32'(a_err[0]), 32'h1);
    idle(1);
    chk("t6_err_c2", 0, 32'(a_err[0]), STICKY ? 32'h1 : 32'h0);
    idle(9);
    chk("t6_err_c10", 0, 32'(a_err[0]), STICKY ? 32'h1 : 32'h0);
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_clr", 0, 32'(a_err[0]), 32'h0);
    drive(4'hE, 1'b1, 1'b0, 1'b1);
    chk("t6_clr_vs_set", 0, 32'(a_err[0]), 32'h1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
